bitrev_ctrl: RTL

- Ping-pong bank controller for the bit-reversal datapath.
- Owns the two sample banks, each 2^K x DW sync-read SRAM outside this block.
- Drives write addresses in natural order and read addresses in bit-reversed order.
- Runs the valid/ready handshakes on both stream sides, so one bank fills while the other drains at full throughput.
- Carries no data, only control and addresses; sits between the stream interfaces and the bank memories.

---
 rtl/bitrev_pkg.sv | 31 +++
 rtl/bitrev_ctrl_if.sv | 34 +++
 rtl/bitrev_bank_fsm.sv | 48 ++++
 rtl/bitrev_ctrl.sv | 115 +++++++++++
 4 files changed

// File: rtl/bitrev_pkg.sv
// Shared types and helpers for the bit-reversal bank controller.
// Bank lifecycle encoding, frame-size clamping and low-k-bit reversal.
package bitrev_pkg;

    // Widest address the reversal helper handles; K must not exceed this.
    localparam int BR_W = 16;

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    function automatic int unsigned clamp_k(input int unsigned k, input int unsigned kmax);
        return (k == 0 || k > kmax) ? kmax : k;
    endfunction

    // Mask to the low k bits, mirror the whole word, then shift the mirrored field back down.
    function automatic logic [BR_W-1:0] bitrev_k(input logic [BR_W-1:0] x, input int unsigned k);
        logic [BR_W-1:0] m;
        logic [BR_W-1:0] r;
        m = x & BR_W'((32'd1 << k) - 32'd1);
        r = '0;
        for (int i = 0; i < BR_W; i++) begin
            r[BR_W-1-i] = m[i];
        end
        return r >> (BR_W - k);
    endfunction

endpackage

// File: rtl/bitrev_ctrl_if.sv
// Stream handshakes, frame-size config and bank memory control for bitrev_ctrl.
// slave is the controller's view; master is the surrounding stream/memory side.
interface bitrev_ctrl_if #(
    parameter int K  = 10,
    parameter int KW = $clog2(K + 1)
);
    logic [KW-1:0] cfg_k_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic          out_last_o;
    logic          wr_en_o;
    logic          wr_bank_o;
    logic [K-1:0]  wr_addr_o;
    logic          rd_en_o;
    logic          rd_bank_o;
    logic [K-1:0]  rd_addr_o;
    logic          busy_o;

    modport slave (
        input  cfg_k_i, in_valid_i, out_ready_i,
        output in_ready_o, out_valid_o, out_last_o,
        output wr_en_o, wr_bank_o, wr_addr_o,
        output rd_en_o, rd_bank_o, rd_addr_o, busy_o
    );

    modport master (
        output cfg_k_i, in_valid_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_last_o,
        input  wr_en_o, wr_bank_o, wr_addr_o,
        input  rd_en_o, rd_bank_o, rd_addr_o, busy_o
    );
endinterface

// File: rtl/bitrev_bank_fsm.sv
// Lifecycle of one sample bank (FREE->FILLING->FULL->DRAINING) plus its latched frame size.
// State changes on the edge that ends the triggering cycle; no handshake of its own.
module bitrev_bank_fsm
    import bitrev_pkg::*;
#(
    parameter int KW = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          start,
    input  logic [KW-1:0] k_in,
    input  logic          fill_done,
    input  logic          drain_start,
    input  logic          drain_done,
    output bank_state_e   state,
    output logic [KW-1:0] k
);

    bank_state_e state_q, state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FREE:     if (start)       state_d = FILLING;
            FILLING:  if (fill_done)   state_d = FULL;
            FULL:     if (drain_start) state_d = DRAINING;
            DRAINING: if (drain_done)  state_d = FREE;
            default:                   state_d = FREE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FREE;
            k       <= '0;
        end else if (clr_i) begin
            state_q <= FREE;
            k       <= '0;
        end else begin
            state_q <= state_d;
            if (start) k <= k_in;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/bitrev_ctrl.sv
// Ping-pong bank controller: natural-order writes, bit-reversed reads, no data path.
// Output valid 2 cycles after the last write of a frame; in_ready drops only when both banks hold frames.
module bitrev_ctrl
    import bitrev_pkg::*;
#(
    parameter int K  = 10,
    parameter int KW = $clog2(K + 1)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    bitrev_ctrl_if.slave bus
);

    bank_state_e   bank_st [2];
    logic [KW-1:0] bank_k  [2];
    logic [1:0]    bank_start, bank_fill_done, bank_drain_start, bank_drain_done;

    logic          wr_bank, rd_bank;
    logic [K-1:0]  wr_cnt, rd_cnt;
    logic          out_valid_q, out_last_q;

    logic [KW-1:0] cfg_k_eff, wr_k, rd_k;
    logic          in_ready, wr_hs, wr_last, readable, rd_en, rd_last;

    function automatic logic [K-1:0] last_of(input logic [KW-1:0] kk);
        return K'((32'd1 << kk) - 32'd1);
    endfunction

    assign cfg_k_eff = KW'(clamp_k(32'(bus.cfg_k_i), 32'(K)));
    // A FREE bank has no latched size yet, so its first write uses the live config.
    assign wr_k      = (bank_st[wr_bank] == FREE) ? cfg_k_eff : bank_k[wr_bank];
    assign rd_k      = bank_k[rd_bank];

    assign in_ready  = (bank_st[wr_bank] == FREE) || (bank_st[wr_bank] == FILLING);
    assign wr_hs     = bus.in_valid_i & in_ready;
    assign wr_last   = wr_hs && (wr_cnt == last_of(wr_k));

    assign readable  = (bank_st[rd_bank] == FULL) || (bank_st[rd_bank] == DRAINING);
    assign rd_en     = readable & (~out_valid_q | bus.out_ready_i);
    assign rd_last   = rd_en && (rd_cnt == last_of(rd_k));

    for (genvar b = 0; b < 2; b++) begin : g_bank
        localparam logic BSEL = 1'(b);

        assign bank_start[b]       = wr_hs   & (wr_bank == BSEL) & (bank_st[b] == FREE);
        assign bank_fill_done[b]   = wr_last & (wr_bank == BSEL);
        assign bank_drain_start[b] = rd_en   & (rd_bank == BSEL) & (bank_st[b] == FULL);
        assign bank_drain_done[b]  = rd_last & (rd_bank == BSEL);

        bitrev_bank_fsm #(.KW(KW)) u_fsm (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .clr_i       (clr_i),
            .start       (bank_start[b]),
            .k_in        (cfg_k_eff),
            .fill_done   (bank_fill_done[b]),
            .drain_start (bank_drain_start[b]),
            .drain_done  (bank_drain_done[b]),
            .state       (bank_st[b]),
            .k           (bank_k[b])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (clr_i) begin
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            if (wr_hs) begin
                if (wr_last) begin
                    wr_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_cnt  <= wr_cnt + 1'b1;
                end
            end
            if (rd_en) begin
                if (rd_last) begin
                    rd_cnt  <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_cnt  <= rd_cnt + 1'b1;
                end
            end
            out_valid_q <= rd_en | (out_valid_q & ~bus.out_ready_i);
            // The last flag travels with its sample through stalls and clears once that sample is taken.
            if (rd_en)                out_last_q <= rd_last;
            else if (bus.out_ready_i) out_last_q <= 1'b0;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_last_o  = out_last_q;
    assign bus.wr_en_o     = wr_hs;
    assign bus.wr_bank_o   = wr_bank;
    assign bus.wr_addr_o   = wr_cnt;
    assign bus.rd_en_o     = rd_en;
    assign bus.rd_bank_o   = rd_bank;
    assign bus.rd_addr_o   = K'(bitrev_k(BR_W'(rd_cnt), 32'(rd_k)));
    assign bus.busy_o      = (bank_st[0] != FREE) || (bank_st[1] != FREE);

endmodule
